// File: rtl/m68k_bus_pkg.sv
// Shared 68k bus-termination types: FSM states, chip-select indices and the
// default wait-state/timeout settings for the CPLD glue logic.
package m68k_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } bus_state_t;

    localparam logic [2:0] CS_BOOT = 3'd0;
    localparam logic [2:0] CS_RAM  = 3'd1;
    localparam logic [2:0] CS_IO   = 3'd2;
    localparam logic [2:0] CS_EXT  = 3'd3;
    localparam logic [2:0] CS_NONE = 3'd4;

    localparam int WS_BOOT_DEF = 0;
    localparam int WS_RAM_DEF  = 1;
    localparam int WS_IO_DEF   = 3;
    localparam int TIMEOUT_DEF = 64;
    localparam int CW_DEF      = 8;

    // Lowest set bit wins so overlapping decodes resolve deterministically.
    function automatic logic [2:0] cs_to_sel(input logic [3:0] cs);
        if (cs[0]) return CS_BOOT;
        if (cs[1]) return CS_RAM;
        if (cs[2]) return CS_IO;
        if (cs[3]) return CS_EXT;
        return CS_NONE;
    endfunction

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// reset value so idle-high strobes come out of reset inactive.
module m68k_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s_p0;
    logic s_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_p0 <= RST_VAL;
            s_p1 <= RST_VAL;
        end else begin
            s_p0 <= d;
            s_p1 <= s_p0;
        end
    end

    assign q = s_p1;

endmodule

// File: rtl/m68k_dtack_gen.sv
// 68k bus-cycle termination: inserts per-select wait states before DTACK,
// forwards an external device's ready, and raises BERR on a watchdog timeout.
module m68k_dtack_gen
    import m68k_bus_pkg::*;
#(
    parameter int WS0     = WS_BOOT_DEF,
    parameter int WS1     = WS_RAM_DEF,
    parameter int WS2     = WS_IO_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic       clk16,
    input  logic       reset,
    input  logic       as_n,
    input  logic [3:0] cs,
    input  logic       dtack_trig,
    output logic       dtack_n,
    output logic       berr_n,
    output logic       timeout_evt
);

    localparam logic [CW-1:0] WS0_C   = CW'(WS0);
    localparam logic [CW-1:0] WS1_C   = CW'(WS1);
    localparam logic [CW-1:0] WS2_C   = CW'(WS2);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic          as_s;
    bus_state_t    state, state_nx;
    logic [2:0]    sel, sel_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          trig_q;
    logic          ws_hit;

    m68k_sync2 #(.RST_VAL(1'b1)) u_as_sync (
        .clk   (clk16),
        .reset (reset),
        .d     (as_n),
        .q     (as_s)
    );

    always_comb begin
        ws_hit = 1'b0;
        case (sel)
            CS_BOOT: ws_hit = (cnt == WS0_C);
            CS_RAM:  ws_hit = (cnt == WS1_C);
            CS_IO:   ws_hit = (cnt == WS2_C);
            default: ws_hit = 1'b0;
        endcase
    end

    // Abort beats termination, and termination beats the watchdog.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (!as_s) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                    sel_nx   = cs_to_sel(cs);
                end
            end
            WAIT: begin
                cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;
                if (as_s)
                    state_nx = IDLE;
                else if (ws_hit || (sel == CS_EXT && trig_q))
                    state_nx = ACK;
                else if (cnt == TO_LAST)
                    state_nx = ERR;
            end
            ACK, ERR: begin
                if (as_s)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they switch on the
    // same edge as the FSM transition.
    always_ff @(posedge clk16) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= CS_NONE;
            cnt         <= '0;
            trig_q      <= 1'b0;
            dtack_n     <= 1'b1;
            berr_n      <= 1'b1;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nx;
            sel         <= sel_nx;
            cnt         <= cnt_nx;
            trig_q      <= dtack_trig;
            dtack_n     <= (state_nx != ACK);
            berr_n      <= (state_nx != ERR);
            timeout_evt <= (state_nx == ERR) && (state != ERR);
        end
    end

endmodule

// File: tb/tb_m68k_dtack_gen.sv
// Bench for m68k_dtack_gen: directed and randomized bus cycles checked edge by
// edge against an edge-number model of the termination rules.
module tb_m68k_dtack_gen;
    import m68k_bus_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int WS [3] = '{0, 1, 3};

    logic       clk16 = 1'b0;
    logic       reset = 1'b1;
    logic       as_n  = 1'b1;
    logic [3:0] cs    = 4'b0000;
    logic       dtack_trig = 1'b0;
    logic       dtack_n;
    logic       berr_n;
    logic       timeout_evt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk16 = ~clk16;

    m68k_dtack_gen dut (
        .clk16       (clk16),
        .reset       (reset),
        .as_n        (as_n),
        .cs          (cs),
        .dtack_trig  (dtack_trig),
        .dtack_n     (dtack_n),
        .berr_n      (berr_n),
        .timeout_evt (timeout_evt)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk16);
            as_n = 1'b1;
            dtack_trig = 1'b0;
            @(posedge clk16); #1;
            check($sformatf("%s idle dtack_n", tag), dtack_n, 1'b1);
            check($sformatf("%s idle berr_n", tag), berr_n, 1'b1);
        end
    endtask

    // One bus cycle: as_n low from E0, sampled high again from edge r.
    // dtack_trig is high on edges ta..tb (tb < ta means never).
    task automatic run_cycle(input logic [3:0] c, input int r, input int ta,
                             input int tb, input bit scramble, input string tag);
        int  sel, ack_e, err_e, term, k0;
        bit  is_ack, aborted;
        logic exp_d, exp_b, exp_t;
        sel = 4;
        for (int i = 3; i >= 0; i--) if (c[i]) sel = i;
        ack_e = 100000;
        if (sel < 3) ack_e = 3 + WS[sel];
        else if (sel == 3) begin
            k0 = (ta > 2) ? ta : 2;
            if (k0 <= tb) ack_e = k0 + 1;
        end
        err_e   = 2 + TIMEOUT;
        is_ack  = (ack_e <= err_e);
        term    = is_ack ? ack_e : err_e;
        aborted = (r + 2 <= term);
        for (int e = 0; e <= r + 4; e++) begin
            @(negedge clk16);
            if (e == 0) cs = c;
            else if (scramble && e > 3) cs = 4'($urandom);
            as_n = (e >= r);
            dtack_trig = (e >= ta && e <= tb);
            @(posedge clk16); #1;
            exp_d = !(!aborted && is_ack && e >= term && e < r + 2);
            exp_b = !(!aborted && !is_ack && e >= term && e < r + 2);
            exp_t = !aborted && !is_ack && e == term;
            check($sformatf("%s dtack_n E%0d", tag, e), dtack_n, exp_d);
            check($sformatf("%s berr_n E%0d", tag, e), berr_n, exp_b);
            check($sformatf("%s timeout_evt E%0d", tag, e), timeout_evt, exp_t);
        end
        dtack_trig = 1'b0;
    endtask

    initial begin
        int r, ta, tb;
        logic [3:0] c;

        // Reset held with an active-looking request.
        as_n = 1'b0;
        cs   = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk16);
            @(posedge clk16); #1;
            check("reset dtack_n", dtack_n, 1'b1);
            check("reset berr_n", berr_n, 1'b1);
            check("reset timeout_evt", timeout_evt, 1'b0);
            check("reset state idle", dut.state === IDLE, 1'b1);
        end
        reset = 1'b0;
        run_cycle(4'b0001, 6, 0, -1, 1'b0, "boot_after_reset");
        idle(2, "g1");

        run_cycle(4'b0100, 10, 0, -1, 1'b0, "io_ws3");
        idle(2, "g2");
        run_cycle(4'b1000, 15, 10, 10, 1'b0, "ext_pulse");
        idle(2, "g3");
        run_cycle(4'b1000, 8, 0, 8, 1'b0, "ext_held");
        idle(2, "g4");
        run_cycle(4'b0000, 70, 0, -1, 1'b0, "timeout");
        idle(2, "g5");
        run_cycle(4'b1000, 70, 65, 70, 1'b0, "ack_vs_err");
        idle(2, "g6");
        run_cycle(4'b0100, 4, 0, -1, 1'b0, "abort");
        run_cycle(4'b0001, 5, 0, -1, 1'b0, "after_abort");
        idle(1, "g7");
        run_cycle(4'b0110, 8, 0, -1, 1'b0, "multi_sel");
        idle(2, "g8");

        // Reset in the middle of an acknowledged cycle.
        @(negedge clk16);
        cs   = 4'b0010;
        as_n = 1'b0;
        repeat (5) @(posedge clk16);
        #1;
        check("midreset pre dtack_n", dtack_n, 1'b0);
        @(negedge clk16);
        reset = 1'b1;
        @(posedge clk16); #1;
        check("midreset dtack_n", dtack_n, 1'b1);
        check("midreset berr_n", berr_n, 1'b1);
        check("midreset state idle", dut.state === IDLE, 1'b1);
        @(negedge clk16);
        reset = 1'b0;
        as_n  = 1'b1;
        idle(3, "g9");

        for (int n = 0; n < 20; n++) begin
            c  = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 72) : $urandom_range(1, 20);
            ta = $urandom_range(0, r);
            tb = ($urandom_range(0, 3) == 0) ? -1 : ta + $urandom_range(0, 3);
            run_cycle(c, r, ta, tb, 1'b1, $sformatf("rand%0d", n));
            idle(1 + $urandom_range(0, 2), $sformatf("rg%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
